// File: rtl/async_bus_master_if.sv
// Host-side handshake and bus control signals of the asynchronous bus master.
// The shared data bus is a separate inout port on the master.
interface async_bus_master_if;
    logic       req;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       CS_;
    logic       OE_;
    logic       WR_;
    logic [7:0] Addr;

    modport master (
        input  req, wr, addr, wdata,
        output busy, done, rdata, CS_, OE_, WR_, Addr
    );

    modport slave (
        output req, wr, addr, wdata,
        input  busy, done, rdata, CS_, OE_, WR_, Addr
    );
endinterface

// File: rtl/async_bus_master.sv
// Asynchronous SRAM-style bus master: SETUP / STROBE / HOLD timed by a 4-bit
// down-counter, with every bus-facing signal driven straight from a flop.
module async_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                 clk,
    input  logic                 rst_,
    async_bus_master_if.master   bus,
    inout  wire  [7:0]           data_bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       cs_n_q, cs_n_d;
    logic       oe_n_q, oe_n_d;
    logic       wr_n_q, wr_n_d;
    logic       drv_q, drv_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;

    // Next-state and next-output logic; counter value 0 marks the last cycle of a phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cs_n_d  = cs_n_q;
        oe_n_d  = oe_n_q;
        wr_n_d  = wr_n_q;
        drv_d   = drv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    wr_d    = bus.wr;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cs_n_d  = 1'b0;
                    drv_d   = bus.wr;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                    wr_n_d  = ~wr_q;
                    oe_n_d  = wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    wr_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = data_bus;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    drv_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                cs_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                drv_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous abort to the quiet bus state.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            cs_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            drv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cs_n_q  <= cs_n_d;
            oe_n_q  <= oe_n_d;
            wr_n_q  <= wr_n_d;
            drv_q   <= drv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.CS_   = cs_n_q;
    assign bus.OE_   = oe_n_q;
    assign bus.WR_   = wr_n_q;
    assign bus.Addr  = addr_q;

    // Only writes ever enable the driver, so it cannot collide with a target during OE_ low.
    assign data_bus = drv_q ? wdata_q : 8'hZZ;

endmodule

// File: tb/tb_async_bus_master.sv
// Scoreboard bench for async_bus_master: default-timing and 3/1/2-timing instances,
// each with a small target memory model on its own data bus.
module tb_async_bus_master;

    logic       clk;
    logic       rst_;
    logic       tinit;
    logic       sel_t;
    logic       req_t, wr_t;
    logic [7:0] addr_t, wdata_t;

    int n_chk;
    int n_pass;

    logic [7:0] ref_mem [2][256];
    logic [7:0] rdata_m [2];
    logic [7:0] sb [$];
    logic [7:0] tmem0 [256];
    logic [7:0] tmem1 [256];

    wire [7:0] dbus0;
    wire [7:0] dbus1;

    async_bus_master_if b0 ();
    async_bus_master_if b1 ();

    assign b0.req   = req_t & ~sel_t;
    assign b1.req   = req_t & sel_t;
    assign b0.wr    = wr_t;
    assign b1.wr    = wr_t;
    assign b0.addr  = addr_t;
    assign b1.addr  = addr_t;
    assign b0.wdata = wdata_t;
    assign b1.wdata = wdata_t;

    async_bus_master dut0 (
        .clk      (clk),
        .rst_     (rst_),
        .bus      (b0),
        .data_bus (dbus0)
    );

    async_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk      (clk),
        .rst_     (rst_),
        .bus      (b1),
        .data_bus (dbus1)
    );

    // Target models: drive memory contents while selected and OE_ low, store on WR_ low edges.
    assign dbus0 = (!b0.CS_ && !b0.OE_) ? tmem0[b0.Addr] : 8'hZZ;
    assign dbus1 = (!b1.CS_ && !b1.OE_) ? tmem1[b1.Addr] : 8'hZZ;

    always @(posedge clk) begin
        if (tinit) begin
            for (int i = 0; i < 256; i++) begin
                tmem0[i] <= (i == 2) ? 8'h3C : 8'h00;
                tmem1[i] <= (i == 2) ? 8'h5A : 8'h00;
            end
        end else begin
            if (!b0.CS_ && !b0.WR_) tmem0[b0.Addr] <= dbus0;
            if (!b1.CS_ && !b1.WR_) tmem1[b1.Addr] <= dbus1;
        end
    end

    wire       cs_m    = sel_t ? b1.CS_   : b0.CS_;
    wire       oe_m    = sel_t ? b1.OE_   : b0.OE_;
    wire       wrn_m   = sel_t ? b1.WR_   : b0.WR_;
    wire       busy_m  = sel_t ? b1.busy  : b0.busy;
    wire       done_m  = sel_t ? b1.done  : b0.done;
    wire [7:0] rdata_x = sel_t ? b1.rdata : b0.rdata;
    wire [7:0] addr_m  = sel_t ? b1.Addr  : b0.Addr;
    wire [7:0] dbus_m  = sel_t ? dbus1    : dbus0;
    wire       drv_m   = sel_t ? dut1.drv_q : dut0.drv_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_cs"},   32'(cs_m),    32'd1);
        check({tag, "_oe"},   32'(oe_m),    32'd1);
        check({tag, "_wr"},   32'(wrn_m),   32'd1);
        check({tag, "_busy"}, 32'(busy_m),  32'd0);
        check({tag, "_done"}, 32'(done_m),  32'd0);
        check({tag, "_drv"},  32'(drv_m),   32'd0);
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            check_quiet("idle");
        end
    endtask

    // One transaction on the selected instance, checked cycle by cycle from the accept edge.
    task automatic run_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                           input bit keep, input bit started, input int inj, input int abort_k);
        int s, t, h, tot, si;
        logic [7:0] exp_rd;
        bit st;
        si  = sel_t ? 1 : 0;
        s   = sel_t ? 3 : 1;
        t   = sel_t ? 1 : 2;
        h   = sel_t ? 2 : 1;
        tot = s + t + h;
        if (!started) @(negedge clk);
        req_t   = 1'b1;
        wr_t    = w;
        addr_t  = a;
        wdata_t = d;
        if (w) begin
            ref_mem[si][a] = d;
            exp_rd = rdata_m[si];
        end else begin
            exp_rd = ref_mem[si][a];
            rdata_m[si] = exp_rd;
        end
        sb.push_back(exp_rd);
        @(posedge clk);
        #1;
        if (!keep) req_t = 1'b0;
        for (int k = 1; k <= tot + 1; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst_ = 1'b0;
                #1;
                check_quiet("rst_abort");
                check("rst_rdata", 32'(rdata_x), 32'h00);
                check("rst_addr",  32'(addr_m),  32'h00);
                @(negedge clk);
                rst_ = 1'b1;
                idle_check(tot + 2);
                sb.delete();
                rdata_m[si] = 8'h00;
                return;
            end
            st = (k > s) && (k <= s + t);
            check("cs",   32'(cs_m),   (k <= tot) ? 32'd0 : 32'd1);
            check("wr_n", 32'(wrn_m),  (w && st) ? 32'd0 : 32'd1);
            check("oe_n", 32'(oe_m),   (!w && st) ? 32'd0 : 32'd1);
            check("busy", 32'(busy_m), (k <= tot) ? 32'd1 : 32'd0);
            check("done", 32'(done_m), (k == tot + 1) ? 32'd1 : 32'd0);
            check("drv",  32'(drv_m),  (w && k <= tot) ? 32'd1 : 32'd0);
            check("addr", 32'(addr_m), 32'(a));
            if (w && k <= tot) check("wbus", 32'(dbus_m), 32'(d));
            if (!w && st) check("rbus", 32'(dbus_m), 32'(ref_mem[si][a]));
            if (done_m) begin
                if (sb.size() == 0) check("sb_empty", 32'd0, 32'd1);
                else check("rdata", 32'(rdata_x), 32'(sb.pop_front()));
            end
            if (inj > 0 && k == inj) begin
                req_t  = 1'b1;
                addr_t = 8'h03;
            end
            if (inj > 0 && k == inj + 1) begin
                req_t  = 1'b0;
                addr_t = a;
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_    = 1'b1;
        tinit   = 1'b1;
        sel_t   = 1'b0;
        req_t   = 1'b0;
        wr_t    = 1'b0;
        addr_t  = 8'h00;
        wdata_t = 8'h00;
        rdata_m[0] = 8'h00;
        rdata_m[1] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = 8'h00;
            ref_mem[1][i] = 8'h00;
        end
        ref_mem[0][2] = 8'h3C;
        ref_mem[1][2] = 8'h5A;

        #1 rst_ = 1'b0;
        #2;
        check_quiet("reset0");
        check("reset0_rdata", 32'(b0.rdata), 32'h00);
        check("reset0_addr",  32'(b0.Addr),  32'h00);
        check("reset1_cs",    32'(b1.CS_),   32'd1);
        check("reset1_busy",  32'(b1.busy),  32'd0);
        repeat (3) @(negedge clk);
        tinit = 1'b0;
        rst_  = 1'b1;
        idle_check(2);

        // default write then read
        run_txn(1'b1, 8'h01, 8'hA5, 1'b0, 1'b0, 0, 0);
        check("tgt_store_a5", 32'(tmem0[1]), 32'hA5);
        run_txn(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 0, 0);

        // request during busy must be ignored
        run_txn(1'b1, 8'h01, 8'h5A, 1'b0, 1'b0, 2, 0);
        idle_check(3);
        check("tgt_addr3_untouched", 32'(tmem0[3]), 32'h00);
        check("tgt_store_5a",        32'(tmem0[1]), 32'h5A);

        // req held high: back-to-back with one CS_-high cycle
        run_txn(1'b1, 8'h10, 8'h77, 1'b1, 1'b0, 0, 0);
        run_txn(1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 0, 0);
        check("tgt_store_77", 32'(tmem0[16]), 32'h77);
        idle_check(2);

        // non-default timing instance
        @(negedge clk);
        sel_t = 1'b1;
        run_txn(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 0, 0);
        idle_check(2);
        sel_t = 1'b0;

        // reset in the second strobe cycle of a write, then a normal read
        run_txn(1'b1, 8'h01, 8'hC3, 1'b0, 1'b0, 0, 3);
        run_txn(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 0, 0);
        idle_check(2);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
